// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// Display words arrive via valid/ready and are swapped in only at frame boundaries or while off.
module seg_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  lzb_en,
    input  logic                  load_valid,
    input  logic [4*N_DIGITS-1:0] load_data,
    input  logic [N_DIGITS-1:0]   load_dp,
    output logic                  load_ready,
    output logic [3:0]            digit_code,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  dp,
    output logic                  frame_end
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {OFF, GUARD, DRIVE} state_t;

    state_t                state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic [4*N_DIGITS-1:0] pend_data, act_data, act_data_d;
    logic [N_DIGITS-1:0]   pend_dp, act_dp, act_dp_d;
    logic                  full, full_d, take, xfer;
    logic [N_DIGITS-1:0]   lz;
    logic [3:0]            code_d, nib;
    logic [N_DIGITS-1:0]   an_d;
    logic                  dp_d, fe_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OFF;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        if (!en) begin
            state_d = OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state)
                OFF: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (GUARD_CYCLES == 0) state_d = DRIVE;
                    else                   state_d = GUARD;
                end
                GUARD: begin
                    cnt_d = cnt + 1'b1;
                    if (cnt == GUARD_LAST) state_d = DRIVE;
                end
                DRIVE: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_d = '0;
                        idx_d = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        if (GUARD_CYCLES == 0) state_d = DRIVE;
                        else                   state_d = GUARD;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // frame_end is a registered copy of "last cycle of the frame", so it doubles as the swap strobe
    always_comb begin
        take       = load_valid && !full;
        xfer       = full && (frame_end || state == OFF);
        act_data_d = xfer ? pend_data : act_data;
        act_dp_d   = xfer ? pend_dp : act_dp;
        full_d     = take ? 1'b1 : (xfer ? 1'b0 : full);
    end

    // Outputs are computed from next-state values and registered, so they line up with the state
    always_comb begin
        lz = '0;
        lz[N_DIGITS-1] = (act_data_d[4*N_DIGITS-1 -: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 1; i--) begin
            lz[i] = (act_data_d[4*i +: 4] == 4'h0) && lz[i+1];
        end
        lz[0]  = 1'b0;
        nib    = act_data_d[4*idx_d +: 4];
        code_d = 4'hF;
        an_d   = '1;
        dp_d   = 1'b0;
        fe_d   = 1'b0;
        if (state_d != OFF) begin
            code_d = (lzb_en && lz[idx_d]) ? 4'hF : nib;
            dp_d   = act_dp_d[idx_d];
        end
        if (state_d == DRIVE) begin
            an_d[idx_d] = 1'b0;
            fe_d        = (idx_d == IDX_LAST) && (cnt_d == SLOT_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            full       <= 1'b0;
            act_data   <= '1;
            act_dp     <= '0;
            load_ready <= 1'b1;
            digit_code <= 4'hF;
            an_n       <= '1;
            dp         <= 1'b0;
            frame_end  <= 1'b0;
        end else begin
            if (take) begin
                pend_data <= load_data;
                pend_dp   <= load_dp;
            end
            full       <= full_d;
            act_data   <= act_data_d;
            act_dp     <= act_dp_d;
            load_ready <= !full_d;
            digit_code <= code_d;
            an_n       <= an_d;
            dp         <= dp_d;
            frame_end  <= fe_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
// Expected per-cycle output vectors are queued when stimulus is applied and popped at each negedge.
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int FRAME = N * SLOT;

    typedef logic [10:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          lzb_en;
    logic          load_valid;
    logic [15:0]   load_data;
    logic [3:0]    load_dp;
    logic          load_ready;
    logic [3:0]    digit_code;
    logic [3:0]    an_n;
    logic          dp;
    logic          frame_end;

    vec_t sb[$];
    vec_t got, exp;
    int   checks = 0;
    int   errors = 0;

    seg_scan_ctrl #(.N_DIGITS(N), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(GUARD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .lzb_en(lzb_en),
        .load_valid(load_valid), .load_data(load_data), .load_dp(load_dp),
        .load_ready(load_ready), .digit_code(digit_code), .an_n(an_n),
        .dp(dp), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    // Vector layout: {load_ready, an_n[3:0], digit_code[3:0], dp, frame_end}
    function automatic void push_slots(input logic [15:0] data, input logic [3:0] dpm,
                                       input logic lzb, input logic rdy, input int first, input int last);
        for (int p = first; p <= last; p++) begin
            int d = p / SLOT;
            int c = p % SLOT;
            logic [3:0] an, code;
            an   = (c < GUARD) ? 4'hF : ~(4'b0001 << d);
            code = data[4*d +: 4];
            if (lzb && d > 0 && (data >> (4*d)) == 16'h0) code = 4'hF;
            sb.push_back({rdy, an, code, dpm[d], (p == FRAME - 1)});
        end
    endfunction

    function automatic void push_off(input logic rdy);
        sb.push_back({rdy, 4'hF, 4'hF, 1'b0, 1'b0});
    endfunction

    task automatic wait_frame_end();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_end !== 1'b1 && n < 100);
        checks++;
        if (frame_end !== 1'b1) begin
            errors++;
            $display("FAIL frame_sync frame_end=%b required 1 within 100 cycles", frame_end);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; lzb_en = 1'b0;
        load_valid = 1'b0; load_data = '0; load_dp = '0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (an_n !== 4'hF)      begin errors++; $display("FAIL reset_an_n got %b exp 1111", an_n); end
        if (digit_code !== 4'hF) begin errors++; $display("FAIL reset_code got %h exp f", digit_code); end
        if (dp !== 1'b0)        begin errors++; $display("FAIL reset_dp got %b exp 0", dp); end
        if (frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end got %b exp 0", frame_end); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", load_ready); end
        rst_n = 1'b1;
        push_slots(16'hFFFF, 4'b0000, 1'b0, 1'b1, 0, FRAME - 1);
        push_slots(16'hFFFF, 4'b0000, 1'b0, 1'b1, 0, FRAME - 1);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            got = {load_ready, an_n, digit_code, dp, frame_end};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL idle_scan k=%0d got %b exp %b", k, got, exp); end
        end
    endtask

    task automatic test_load_boundary();
        wait_frame_end();
        repeat (11) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h1234; load_dp = 4'b0100;
        checks++;
        if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_before got %b exp 1", load_ready); end
        push_slots(16'hFFFF, 4'b0000, 1'b0, 1'b0, 11, FRAME - 1);
        push_slots(16'h1234, 4'b0100, 1'b0, 1'b1, 0, FRAME - 1);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) load_valid = 1'b0;
            got = {load_ready, an_n, digit_code, dp, frame_end};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL load_boundary k=%0d got %b exp %b", k, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        wait_frame_end();
        repeat (5) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h1111; load_dp = 4'b0000;
        push_slots(16'h1234, 4'b0100, 1'b0, 1'b0, 5, FRAME - 1);
        push_slots(16'h1111, 4'b0000, 1'b0, 1'b1, 0, 0);
        push_slots(16'h1111, 4'b0000, 1'b0, 1'b0, 1, FRAME - 1);
        push_slots(16'h2222, 4'b0000, 1'b0, 1'b1, 0, FRAME - 1);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0)  load_data = 16'h2222;
            if (k == 28) load_valid = 1'b0;
            got = {load_ready, an_n, digit_code, dp, frame_end};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL back_to_back k=%0d got %b exp %b", k, got, exp); end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] tdata [3] = '{16'h0070, 16'h0000, 16'h0070};
        logic [3:0]  tdp   [3] = '{4'b0001, 4'b1000, 4'b0000};
        logic        tlzb  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            wait_frame_end();
            en = 1'b0; lzb_en = tlzb[i];
            load_valid = 1'b1; load_data = tdata[i]; load_dp = tdp[i];
            push_off(1'b0);
            push_slots(tdata[i], tdp[i], tlzb[i], 1'b1, 0, FRAME - 1);
            for (int k = 0; sb.size() > 0; k++) begin
                @(negedge clk);
                if (k == 0) begin en = 1'b1; load_valid = 1'b0; end
                got = {load_ready, an_n, digit_code, dp, frame_end};
                exp = sb.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL lzb case=%0d k=%0d got %b exp %b", i, k, got, exp); end
            end
        end
    endtask

    task automatic test_enable_drop();
        wait_frame_end();
        repeat (21) @(negedge clk);
        en = 1'b0;
        push_off(1'b1);
        push_off(1'b0);
        push_off(1'b1);
        push_off(1'b1);
        push_slots(16'h5678, 4'b0010, 1'b0, 1'b1, 0, FRAME - 1);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) begin load_valid = 1'b1; load_data = 16'h5678; load_dp = 4'b0010; end
            if (k == 1) load_valid = 1'b0;
            if (k == 3) en = 1'b1;
            got = {load_ready, an_n, digit_code, dp, frame_end};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL enable_drop k=%0d got %b exp %b", k, got, exp); end
        end
    endtask

    task automatic test_async_reset();
        wait_frame_end();
        repeat (13) @(negedge clk);
        load_valid = 1'b1; load_data = 16'h9999; load_dp = 4'b1111;
        @(negedge clk);
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin errors++; $display("FAIL pending_ready got %b exp 0", load_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (an_n !== 4'hF)       begin errors++; $display("FAIL async_an_n got %b exp 1111", an_n); end
        if (load_ready !== 1'b1) begin errors++; $display("FAIL async_ready got %b exp 1", load_ready); end
        if (digit_code !== 4'hF) begin errors++; $display("FAIL async_code got %h exp f", digit_code); end
        @(negedge clk);
        rst_n = 1'b1;
        push_slots(16'hFFFF, 4'b0000, 1'b0, 1'b1, 0, FRAME - 1);
        for (int k = 0; sb.size() > 0; k++) begin
            @(negedge clk);
            got = {load_ready, an_n, digit_code, dp, frame_end};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL after_async k=%0d got %b exp %b", k, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_load_boundary();
        test_back_to_back();
        test_lzb();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the multi-digit 7-segment display of the DHT11 readout. It holds the current display word of N BCD digits and steps through them one slot at a time. For each slot it drives the active digit's code into the segment encoder and enables exactly one anode. New display words are accepted through a valid/ready handshake and take effect only at a frame boundary, so a half-updated frame is never shown. It also provides leading-zero blanking, per-digit decimal point, and an anti-ghosting guard interval.

## Interface
- N_DIGITS, 4: number of digits scanned; must be ≥ 2.
- SLOT_CYCLES, 50000: clock cycles per digit slot; must be ≥ 2.
- GUARD_CYCLES, 500: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD_CYCLES < SLOT_CYCLES.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- lzb_en  in  1  leading-zero blanking enable.
- load_valid  in  1  a new display word is offered.
- load_data  in  4*N_DIGITS  BCD nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is rightmost.
- load_dp  in  N_DIGITS  decimal-point mask that accompanies load_data.
- load_ready  out  1  controller can accept a word; registered.
- digit_code  out  4  code sent to the segment encoder; 4'hF means blank.
- an_n  out  N_DIGITS  active-low anode enables, one-hot-low while driving.
- dp  out  1  decimal point for the current digit; active-high.
- frame_end  out  1  one-cycle pulse on the last cycle of digit N_DIGITS-1's slot.

## Operation
- Registers:
  - **Pending buffer:** data, dp mask, and a `full` flag.
  - **Active word:** data and dp mask.
  - **Slot counter:** 0..SLOT_CYCLES-1.
  - **Digit index:** 0..N_DIGITS-1.
  - **State:** OFF, GUARD, DRIVE.
- Reset values:
  - an_n = all 1s; digit_code = 4'hF; dp = 0; frame_end = 0; load_ready = 1.
  - Active data = all 4'hF, so the display is blank; active dp mask = 0.
  - Pending buffer empty; counter = 0; index = 0; state = OFF.
- Handshake:
  - Transfer happens on a cycle where load_valid && load_ready; load_data and load_dp are captured into the pending buffer.
  - load_ready = !full, evaluated with the registered full flag.
  - A second word cannot be accepted until the pending buffer drains. Words are never dropped or overwritten.
- Pending → active transfer:
  - Occurs on the frame_end cycle, or on any cycle while the state is OFF.
  - The transfer clears full; load_ready returns to 1 on the next cycle.
  - If the buffer is empty at the frame boundary, the active word is unchanged.
- State machine:
  - **OFF:** an_n all 1s, digit_code 4'hF. Counter and index are held at 0. Goes to GUARD when en = 1.
  - **GUARD:** an_n all 1s. digit_code and dp already show digit[index]. Goes to DRIVE when counter = GUARD_CYCLES-1. If GUARD_CYCLES = 0, this state is skipped and the slot starts directly in DRIVE.
  - **DRIVE:** an_n[index] = 0 and every other bit is 1. When counter = SLOT_CYCLES-1: counter resets to 0, index increments and wraps from N_DIGITS-1 to 0, and the state goes to GUARD.
  - From any state, en = 0 forces OFF on the next edge, mid-slot included. The counter and index clear to 0.
- Digit value:
  - digit_code = active nibble[index], passed through unchanged. Values 10–15 reach the encoder, which renders them blank.
  - Leading-zero blanking applies when lzb_en = 1. Digit i > 0 shows 4'hF if it and every higher digit equal 0. Digit 0 is never blanked.
  - dp = active dp mask[index] in GUARD and DRIVE, and 0 in OFF. Blanking does not suppress dp.
- Outputs are registered and change only on clk edges, apart from reset.

## Timing
- Slot = SLOT_CYCLES cycles: GUARD_CYCLES with anodes off, then the rest in DRIVE.
- Frame = N_DIGITS × SLOT_CYCLES cycles.
- digit_code changes on the first cycle of a slot, which is at least GUARD_CYCLES cycles before its anode asserts. When GUARD_CYCLES = 0, the code and the anode change on the same edge.
- Load latency while scanning:
  - The word is visible starting at digit 0 of the frame after the next frame_end.
  - Worst case ≈ 1 frame + 1 cycle.
- Load latency in OFF: the active word updates 1 cycle after acceptance.
- Simultaneous acceptance and frame_end, when the buffer is empty: the captured word waits for the following frame_end.
- After reset deasserts with en = 1: the first cycle is OFF → GUARD, and an_n[0] falls at cycle GUARD_CYCLES+1.

## Test plan
All scenarios use N_DIGITS = 4, SLOT_CYCLES = 8, GUARD_CYCLES = 2 unless stated.

- **Reset and idle scan:** reset with en = 1 and no load. an_n steps 1110 → 1101 → 1011 → 0111, each low for 6 cycles separated by 2 all-high cycles. digit_code = 4'hF throughout. frame_end pulses every 32 cycles.
- **Load at a frame boundary:** load 16'h1234 with dp = 4'b0100 mid-frame. load_ready drops the next cycle. The display is unchanged until frame_end. The next frame shows codes 4, 3, 2, 1 with dp = 1 only on digit 2. load_ready = 1 the cycle after frame_end.
- **Back-pressure:** hold load_valid with 16'h1111, then 16'h2222, within one frame. The second word is accepted only after frame_end. Each word is displayed for at least one full frame; none is lost.
- **Leading-zero blanking:**
  - 16'h0070 with lzb_en = 1 gives codes 0, 7, F, F.
  - 16'h0000 gives 0, F, F, F.
  - lzb_en = 0 shows every digit.
- **Enable dropped mid-slot:** deassert en during DRIVE of digit 2. Next cycle an_n = 1111 and digit_code = F. A word loaded while off becomes active after 1 cycle. Re-enabling restarts at digit 0 in GUARD.
- **Async reset mid-frame:** assert rst_n = 0 between clock edges while digit 1 is driving with a pending word. an_n = 1111 and load_ready = 1 immediately. The pending word is discarded, and after release digit_code = F.
